// File: rtl/app_lock_system.sv
// Four-digit passcode comparator with a registered unlock flag and an optional
// failed-attempt lockout (MAX_FAILS = 0 leaves the lockout out of play).
module app_lock_system #(
  parameter int unsigned DIGIT_W        = 4,
  parameter int unsigned MAX_FAILS      = 0,
  parameter int unsigned LOCKOUT_CYCLES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DIGIT_W-1:0] digit1,
  input  logic [DIGIT_W-1:0] digit2,
  input  logic [DIGIT_W-1:0] digit3,
  input  logic [DIGIT_W-1:0] digit4,
  input  logic [DIGIT_W-1:0] set1,
  input  logic [DIGIT_W-1:0] set2,
  input  logic [DIGIT_W-1:0] set3,
  input  logic [DIGIT_W-1:0] set4,
  output logic               unlocked
);

  // Keep counters at least one bit wide so MAX_FAILS = 0 still elaborates cleanly.
  localparam int unsigned FailW  = (MAX_FAILS > 0) ? $clog2(MAX_FAILS + 1) : 1;
  localparam int unsigned TimerW = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;
  localparam logic [FailW-1:0]  MaxFails   = FailW'(MAX_FAILS);
  localparam logic [TimerW-1:0] LockCycles = TimerW'(LOCKOUT_CYCLES);
  localparam bit                LockoutEn  = (MAX_FAILS > 0);

  typedef enum logic {StNormal, StLocked} state_e;

  state_e            state_q;
  logic [FailW-1:0]  fail_q;
  logic [TimerW-1:0] timer_q;
  logic              unlocked_q;
  logic              match;
  logic [FailW-1:0]  fail_inc;

  // Exact bitwise equality per position; order matters, no BCD range check.
  assign match = (digit1 == set1) && (digit2 == set2) && (digit3 == set3) && (digit4 == set4);

  assign fail_inc = fail_q + FailW'(1);

  // Lockout FSM and registered unlock flag; reset overrides every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StNormal;
      fail_q     <= '0;
      timer_q    <= '0;
      unlocked_q <= 1'b0;
    end else if (!LockoutEn) begin
      state_q    <= StNormal;
      fail_q     <= '0;
      timer_q    <= '0;
      unlocked_q <= match;
    end else begin
      unique case (state_q)
        StNormal: begin
          if (match) begin
            unlocked_q <= 1'b1;
            fail_q     <= '0;
          end else begin
            unlocked_q <= 1'b0;
            if (fail_inc == MaxFails) begin
              // Threshold reached: hold the count saturated and start the timer.
              fail_q  <= MaxFails;
              timer_q <= LockCycles;
              state_q <= StLocked;
            end else begin
              fail_q <= fail_inc;
            end
          end
        end
        StLocked: begin
          // Correct codes are ignored here; only the timer ends the lockout.
          unlocked_q <= 1'b0;
          if (timer_q <= TimerW'(1)) begin
            timer_q <= '0;
            fail_q  <= '0;
            state_q <= StNormal;
          end else begin
            timer_q <= timer_q - TimerW'(1);
          end
        end
        default: begin
          unlocked_q <= 1'b0;
          fail_q     <= '0;
          timer_q    <= '0;
          state_q    <= StNormal;
        end
      endcase
    end
  end

  assign unlocked = unlocked_q;

endmodule

// File: tb/tb_app_lock_system.sv
// Scoreboarded bench: one instance with lockout disabled, one with
// MAX_FAILS=3 / LOCKOUT_CYCLES=8, both fed the same stimulus.
module tb_app_lock_system;

  localparam int unsigned W        = 4;
  localparam int unsigned MaxF     = 3;
  localparam int unsigned LockLen  = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] digit1, digit2, digit3, digit4;
  logic [W-1:0] set1, set2, set3, set4;
  logic         unl_plain, unl_lock;

  always #5 clk = ~clk;

  app_lock_system #(
    .DIGIT_W(W), .MAX_FAILS(0), .LOCKOUT_CYCLES(LockLen)
  ) u_dut_plain (
    .clk(clk), .reset(reset),
    .digit1(digit1), .digit2(digit2), .digit3(digit3), .digit4(digit4),
    .set1(set1), .set2(set2), .set3(set3), .set4(set4),
    .unlocked(unl_plain)
  );

  app_lock_system #(
    .DIGIT_W(W), .MAX_FAILS(MaxF), .LOCKOUT_CYCLES(LockLen)
  ) u_dut_lock (
    .clk(clk), .reset(reset),
    .digit1(digit1), .digit2(digit2), .digit3(digit3), .digit4(digit4),
    .set1(set1), .set2(set2), .set3(set3), .set4(set4),
    .unlocked(unl_lock)
  );

  logic q_plain[$];
  logic q_lock[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: consecutive misses and remaining lockout edges.
  int   m_fails = 0;
  int   m_left  = 0;

  logic last_p, last_l;
  bit   have_last = 1'b0;

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, push the expected post-edge values, wait for
  // the next falling edge (exactly one rising edge in between).
  task automatic cycle(input logic r, input logic [4*W-1:0] d, input logic [4*W-1:0] s);
    logic m;
    logic e_lock;
    reset  = r;
    digit1 = d[4*W-1 -: W]; digit2 = d[3*W-1 -: W];
    digit3 = d[2*W-1 -: W]; digit4 = d[W-1 -: W];
    set1   = s[4*W-1 -: W]; set2   = s[3*W-1 -: W];
    set3   = s[2*W-1 -: W]; set4   = s[W-1 -: W];
    m = (d == s);
    q_plain.push_back(!r && m);
    if (r) begin
      m_fails = 0; m_left = 0; e_lock = 1'b0;
    end else if (m_left > 0) begin
      m_left--; e_lock = 1'b0;
      if (m_left == 0) m_fails = 0;
    end else if (m) begin
      m_fails = 0; e_lock = 1'b1;
    end else begin
      e_lock = 1'b0;
      m_fails++;
      if (m_fails >= MaxF) m_left = LockLen;
    end
    q_lock.push_back(e_lock);
    @(negedge clk);
  endtask

  // Monitor: one output per rising edge, compared against the queued expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q_plain.size() > 0 && q_lock.size() > 0) begin
        last_p = q_plain.pop_front();
        last_l = q_lock.pop_front();
        check("plain", unl_plain, last_p);
        check("lock", unl_lock, last_l);
        have_last = 1'b1;
      end
    end
  end

  // Between edges the output must hold even though inputs change mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (have_last) begin
        check("plain_hold", unl_plain, last_p);
        check("lock_hold", unl_lock, last_l);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4*W-1:0] s, d, flip;
    // Basic compare, partial match, reset from unlocked.
    cycle(1'b1, 16'h1234, 16'h5678);
    cycle(1'b0, 16'h1234, 16'h5678);
    cycle(1'b0, 16'h5678, 16'h5678);
    cycle(1'b0, 16'h5614, 16'h5678);
    cycle(1'b0, 16'h5678, 16'h5678);
    cycle(1'b1, 16'h5678, 16'h5678);
    cycle(1'b0, 16'h5678, 16'h5678);
    // Latency and ordering.
    cycle(1'b0, 16'h1234, 16'h5678);
    cycle(1'b0, 16'h5678, 16'h5678);
    cycle(1'b0, 16'h6587, 16'h5678);
    // Stored code change, digit values above 9.
    cycle(1'b0, 16'h5678, 16'h9ABC);
    cycle(1'b0, 16'h9ABC, 16'h9ABC);
    cycle(1'b0, 16'hFFFF, 16'hFFFF);
    // Lockout: three misses, then the correct code throughout.
    cycle(1'b1, 16'h0000, 16'h5678);
    repeat (3) cycle(1'b0, 16'h1111, 16'h5678);
    repeat (LockLen + 3) cycle(1'b0, 16'h5678, 16'h5678);
    // Reset during lockout releases it at once.
    cycle(1'b1, 16'h0000, 16'h5678);
    repeat (3) cycle(1'b0, 16'h1111, 16'h5678);
    repeat (3) cycle(1'b0, 16'h5678, 16'h5678);
    cycle(1'b1, 16'h5678, 16'h5678);
    cycle(1'b0, 16'h5678, 16'h5678);
    cycle(1'b0, 16'h5678, 16'h5678);
    // Random traffic biased toward matches and near-misses.
    for (int i = 0; i < 400; i++) begin
      s = 16'($urandom);
      case ($urandom_range(0, 3))
        0, 1: d = s;
        2: begin
          flip = '0;
          flip[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(1, 15));
          d = s ^ flip;
        end
        default: d = 16'($urandom);
      endcase
      cycle($urandom_range(0, 39) == 0, d, s);
    end
    check("drain", (q_plain.size() == 0) && (q_lock.size() == 0), 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/app_lock_system.md
Name: app_lock_system

Overview:
- Four-digit passcode comparator for an application lock.
- The presented code (digit1..digit4) is compared with the stored code (set1..set4) every clock cycle.
- The match result is registered onto unlocked with one cycle of latency.
- An optional failed-attempt lockout is available and is disabled by default. It sits between the keypad/UI capture logic and the app-access gating logic.

Parameters:
- DIGIT_W, 4, width of each digit and set field in bits.
- MAX_FAILS, 0, number of consecutive mismatch cycles that triggers lockout. 0 disables lockout entirely.
- LOCKOUT_CYCLES, 8, lockout duration in clock cycles. Must be ≥1. Ignored when MAX_FAILS=0.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  synchronous, active-high reset.
- digit1  input  DIGIT_W  entered digit, position 1 (most significant position).
- digit2  input  DIGIT_W  entered digit, position 2.
- digit3  input  DIGIT_W  entered digit, position 3.
- digit4  input  DIGIT_W  entered digit, position 4.
- set1  input  DIGIT_W  stored passcode digit, position 1.
- set2  input  DIGIT_W  stored passcode digit, position 2.
- set3  input  DIGIT_W  stored passcode digit, position 3.
- set4  input  DIGIT_W  stored passcode digit, position 4.
- unlocked  output  1  registered unlock flag; 1 means the passcode matched.

Interface notes:
- One clock; reset is synchronous and active-high (ports clk and reset).
- All inputs are sampled on the rising edge of clk.
- There is no valid/strobe handshake: every cycle is a comparison.

Behaviour:
- Reset: on a rising edge with reset=1:
  - unlocked <= 0
  - fail counter <= 0
  - lockout timer <= 0
  - Reset has priority over every other action, including mid-lockout and mid-unlock.
- match = (digit1==set1) && (digit2==set2) && (digit3==set3) && (digit4==set4). Exact bitwise equality of all DIGIT_W bits per position; no BCD range check.
- Values above 9 are compared like any other value.
- Digit order matters. A permuted code is a mismatch.
- With MAX_FAILS=0, on each rising edge with reset=0: unlocked <= match.
  - Latency: 1 cycle. unlocked reflects the inputs sampled at the previous edge.
  - unlocked is purely a function of the last sampled inputs. It is not sticky: a mismatch on the next edge clears it.
- Partial match (any subset of positions equal, but not all four) gives unlocked=0.
- Changing set1..set4 takes effect on the next edge, the same as changing the digits.
- With MAX_FAILS>0, two states, NORMAL and LOCKED:
  - NORMAL, match:
    - unlocked <= 1
    - fail counter <= 0
  - NORMAL, mismatch:
    - unlocked <= 0
    - fail counter increments, saturating at MAX_FAILS.
    - If the incremented value equals MAX_FAILS, go to LOCKED and load the lockout timer with LOCKOUT_CYCLES.
  - LOCKED:
    - unlocked <= 0 regardless of match; the timer decrements each edge.
    - On the edge where the timer reaches 0, return to NORMAL with fail counter = 0.
    - A correct code presented during LOCKED is ignored and does not shorten the lockout.
- Counter widths are sized by $clog2 of MAX_FAILS+1 and LOCKOUT_CYCLES+1. No wrap-around is permitted.
- Outputs never contain X after the first reset edge.

Test Plan:
- Reset, then reset low with digits 1,2,3,4 against set 5,6,7,8 -> after 1 edge, unlocked=0.
- Digits 5,6,7,8 against set 5,6,7,8 -> after 1 edge, unlocked=1.
- Partial match: digits 5,6,1,4 against set 5,6,7,8 -> after 1 edge, unlocked=0 (falls from 1).
- From unlocked=1, assert reset for one edge and release -> unlocked=0 immediately after the reset edge.
- Latency and ordering checks:
  - Digits change to the correct code between edges -> unlocked stays 0 until the next rising edge, then goes to 1.
  - Permuted code 6,5,8,7 -> 0.
- Lockout, with MAX_FAILS=3 and LOCKOUT_CYCLES=8:
  - 3 mismatch cycles, then the correct code -> unlocked stays 0 for 8 cycles.
  - Then unlocked=1 on the next edge once back in NORMAL.
  - Reset during lockout -> unlocked=1 one edge after release with the correct code.
